// File: rtl/serial_subtractor_8bits.sv
// Bit-serial subtractor: Sub_in1 - Sub_in2 - Sub_bin, one bit per clock, LSB first.
// Optional signed-overflow output Sub_ovf is enabled by defining SUB_SIGNED_OVF_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for Sub_start; operands are latched on the accepting edge
// SHIFT | processing one bit per edge, LSB first; last bit publishes result
// DONE  | Sub_done high for exactly one cycle, then back to IDLE
module serial_subtractor_8bits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Sub_start,
  input  logic [WIDTH-1:0] Sub_in1,
  input  logic [WIDTH-1:0] Sub_in2,
  input  logic             Sub_bin,
  output logic             Sub_busy,
  output logic             Sub_done,
  output logic [WIDTH-1:0] Sub_diff,
  output logic             Sub_bout
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             Sub_ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Holds the WIDTH-1 bits produced so far; the final bit joins on the last edge.
  logic [WIDTH-2:0] sh_q, sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
`ifdef SUB_SIGNED_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             bit_a, bit_b, d_bit, br_nxt;
  logic [WIDTH-1:0] res;

  assign bit_a  = op1_q[cnt_q];
  assign bit_b  = op2_q[cnt_q];
  assign d_bit  = bit_a ^ bit_b ^ br_q;
  assign br_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
  assign res    = {d_bit, sh_q};

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update for the handshake and bit-serial borrow chain.
  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
`ifdef SUB_SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (Sub_start) begin
          op1_d   = Sub_in1;
          op2_d   = Sub_in2;
          br_d    = Sub_bin;
          cnt_d   = '0;
          sh_d    = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_d  = res[WIDTH-1:1];
        br_d  = br_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          diff_d  = res;
          bout_d  = br_nxt;
          done_d  = 1'b1;
`ifdef SUB_SIGNED_OVF_EN
          // Borrow into the MSB differs from borrow out of it on signed overflow.
          ovf_d   = br_q ^ br_nxt;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Sub_busy = (state_q != IDLE);
  assign Sub_done = done_q;
  assign Sub_diff = diff_q;
  assign Sub_bout = bout_q;
`ifdef SUB_SIGNED_OVF_EN
  assign Sub_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_8bits.sv
// Self-checking bench for serial_subtractor_8bits (WIDTH=8).
module tb_serial_subtractor_8bits;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in1, in2;
  logic       bin;
  logic       busy, done, bout;
  logic [7:0] diff;
`ifdef SUB_SIGNED_OVF_EN
  logic       ovf;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_subtractor_8bits #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .Sub_start (start),
    .Sub_in1   (in1),
    .Sub_in2   (in2),
    .Sub_bin   (bin),
    .Sub_busy  (busy),
    .Sub_done  (done),
    .Sub_diff  (diff),
    .Sub_bout  (bout)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .Sub_ovf   (ovf)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] exp_diff;
    logic       exp_bout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Plain-arithmetic reference: unsigned and signed interpretations of a - b - c.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output logic [7:0] d, output logic bo, output logic ov);
    int r, s;
    r  = int'(a) - int'(b) - int'(c);
    s  = int'($signed(a)) - int'($signed(b)) - int'(c);
    d  = r[7:0];
    bo = (r < 0);
    ov = (s < -128) || (s > 127);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input string tag);
    logic [7:0] hold;
    int k;
    logic held;
    @(negedge clk);
    hold  = diff;
    in1   = a;
    in2   = b;
    bin   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in1   = 8'($urandom);
    in2   = 8'($urandom);
    bin   = 1'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    k    = 0;
    held = 1'b1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (!done && diff !== hold) held = 1'b0;
    end
    check({tag, "_latency"}, 32'(k), 32'd8);
    check({tag, "_hold"}, 32'(held), 32'd1);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SUB_SIGNED_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: ovf unknown for %s", tag);
`endif
    @(negedge clk);
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [7:0] md;
    logic mb, mo;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h64, 8'h01, 1'b1, 8'h62, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[7] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[8] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef SUB_SIGNED_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_diff,
             vecs[i].exp_bout, vecs[i].exp_ovf, $sformatf("vec%0d", i));

    for (int i = 0; i < 25; i++) begin
      logic [7:0] ra, rb;
      logic rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      model(ra, rb, rc, md, mb, mo);
      run_op(ra, rb, rc, md, mb, mo, $sformatf("rnd%0d", i));
    end

    // Start held high: second request must wait for IDLE, no extra pulses.
    @(negedge clk);
    in1 = 8'h10; in2 = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    in1 = 8'h20; in2 = 8'h02;
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 9) check("held_idle", 32'(busy), 32'd0);
      if (k == 10) begin
        check("held_accept", 32'(busy), 32'd1);
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          check("held_first_at", 32'(k), 32'd8);
          check("held_first_diff", 32'(diff), 32'h0F);
        end else if (pulses == 2) begin
          check("held_second_at", 32'(k), 32'd18);
          check("held_second_diff", 32'(diff), 32'h1E);
        end
      end
    end
    check("held_pulses", 32'(pulses), 32'd2);

    // Reset in the middle of an operation.
    @(negedge clk);
    in1 = 8'hAA; in2 = 8'h55; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    run_op(8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "after_abort");

    // Reset and start on the same edge: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; in1 = 8'h09; in2 = 8'h01;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check("rst_start_nodone", 32'(done), 32'd0);
    check("rst_start_diff", 32'(diff), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
